freq_meter_multi: RTL and testbench

//  Multi-channel successor to the single-channel device-clock meter. It counts events on NCH toggle

---
 rtl/freq_meter_multi_pkg.sv | 23 ++
 rtl/freq_meter_chan.sv | 76 +++++++
 rtl/freq_meter_multi.sv | 84 ++++++++
 tb/tb_freq_meter_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_multi_pkg.sv
// Shared types for the multi-channel toggle-rate meter: FSM encoding,
// per-channel control bundle and the synchronizer warmup length.
package freq_meter_multi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Strobes broadcast from the top-level gate logic to every channel.
    typedef struct packed {
        logic run;    // counting is live this cycle
        logic term;   // last cycle of the gate window
        logic valid;  // dout was refreshed this cycle
    } chan_ctl_t;

    // Synchronizer flush plus one cycle so the edge-detect history is clean.
    function automatic int warmup_len(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/freq_meter_chan.sv
// One measured channel: toggle synchronizer, edge detect, saturating event
// counter, latched result with saturation flag, sticky out-of-range flag.
module freq_meter_chan
    import freq_meter_multi_pkg::*;
#(
    parameter int WIDTH       = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  chan_ctl_t        ctl,
    input  logic             tgl,
    input  logic [WIDTH-1:0] lo_lim,
    input  logic [WIDTH-1:0] hi_lim,
    input  logic             clr_oor,
    output logic [WIDTH-1:0] dout,
    output logic             sat,
    output logic             oor
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   evt;
    logic [WIDTH-1:0]       cnt_q;
    logic                   cnt_full;
    logic                   ovf_q;

    assign evt      = sync_q[SYNC_STAGES-1] ^ prev_q;
    assign cnt_full = &cnt_q;

    // History runs in every state so entering RUN sees no stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // ovf_q remembers events lost once the counter pinned at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (!ctl.run || ctl.term) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (evt) begin
            if (cnt_full) ovf_q <= 1'b1;
            else          cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            sat  <= 1'b0;
        end else if (ctl.term) begin
            dout <= (evt && !cnt_full) ? cnt_q + WIDTH'(1) : cnt_q;
            sat  <= ovf_q | (evt & cnt_full);
        end
    end

    // Limits are judged against the freshly latched dout; a new hit beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            oor <= 1'b0;
        else if (ctl.valid && (dout < lo_lim || dout > hi_lim))
            oor <= 1'b1;
        else if (clr_oor)
            oor <= 1'b0;
    end

endmodule

// File: rtl/freq_meter_multi.sv
// Multi-channel toggle-rate meter: shared gate window FSM and timer, with one
// freq_meter_chan per measured input.
module freq_meter_multi
    import freq_meter_multi_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 12,
    parameter int WINDOW_LOG2 = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH-1:0]       tgl_in,
    input  logic [WIDTH-1:0]     lo_lim,
    input  logic [WIDTH-1:0]     hi_lim,
    input  logic                 clr_oor,
    output logic [NCH*WIDTH-1:0] dout,
    output logic                 valid,
    output logic [NCH-1:0]       sat,
    output logic [NCH-1:0]       oor
);

    localparam int WARM = warmup_len(SYNC_STAGES);
    localparam int WCW  = $clog2(WARM + 1);

    state_t                 state_q, state_d;
    logic [WCW-1:0]         wcnt_q;
    logic [WINDOW_LOG2-1:0] timer_q;
    logic                   run;
    logic                   term;
    chan_ctl_t              ctl;

    // Dropping en in RUN kills counting in the same cycle as the exit.
    assign run  = (state_q == ST_RUN) && en;
    assign term = run && (&timer_q);
    assign ctl  = '{run: run, term: term, valid: valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (en) state_d = ST_WARMUP;
            ST_WARMUP: if (wcnt_q == WCW'(WARM - 1)) state_d = ST_RUN;
            ST_RUN:    if (!en) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= '0;
            timer_q <= '0;
            valid   <= 1'b0;
        end else begin
            wcnt_q  <= (state_q == ST_WARMUP) ? wcnt_q + WCW'(1) : '0;
            timer_q <= run ? timer_q + WINDOW_LOG2'(1) : '0;
            valid   <= term;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        freq_meter_chan #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .ctl     (ctl),
            .tgl     (tgl_in[i]),
            .lo_lim  (lo_lim),
            .hi_lim  (hi_lim),
            .clr_oor (clr_oor),
            .dout    (dout[i*WIDTH +: WIDTH]),
            .sat     (sat[i]),
            .oor     (oor[i])
        );
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
// Directed bench for freq_meter_multi: a 10-bit and a 6-bit instance share
// stimulus and are checked every cycle against a window-level event model.
module tb_freq_meter_multi;

    localparam int NCH = 2, W = 10, W6 = 6, WL = 8, S = 2, N = 256;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    logic [NCH-1:0] tgl = '0;
    logic [W-1:0]   lo10 = '0, hi10 = '1;
    logic [W6-1:0]  lo6 = '0, hi6 = '1;

    logic [NCH*W-1:0]  dout10;
    logic              valid10;
    logic [NCH-1:0]    sat10, oor10;
    logic [NCH*W6-1:0] dout6;
    logic              valid6;
    logic [NCH-1:0]    sat6, oor6;

    int n_cmp = 0, n_fail = 0;
    int per[NCH] = '{4, 8};
    int pcnt[NCH] = '{0, 0};
    int shot_req[NCH] = '{0, 0};
    int shot_done[NCH] = '{0, 0};

    freq_meter_multi #(.NCH(NCH), .WIDTH(W), .WINDOW_LOG2(WL), .SYNC_STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tgl_in(tgl), .lo_lim(lo10), .hi_lim(hi10),
        .clr_oor(clr), .dout(dout10), .valid(valid10), .sat(sat10), .oor(oor10));

    freq_meter_multi #(.NCH(NCH), .WIDTH(W6), .WINDOW_LOG2(WL), .SYNC_STAGES(S)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .tgl_in(tgl), .lo_lim(lo6), .hi_lim(hi6),
        .clr_oor(clr), .dout(dout6), .valid(valid6), .sat(sat6), .oor(oor6));

    always #5 clk = ~clk;

    // Toggle sources: periodic at per[i] clk, plus single shots on request.
    always begin
        @(negedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (shot_req[i] != shot_done[i]) begin
                shot_done[i] = shot_req[i];
                tgl[i] = ~tgl[i];
            end else if (per[i] > 0) begin
                pcnt[i]++;
                if (pcnt[i] >= per[i]) begin
                    pcnt[i] = 0;
                    tgl[i] = ~tgl[i];
                end
            end
        end
    end

    // Model: an input change is seen as an event S edges later; a window is
    // N counting edges after S+1 warmup edges; result = min(events, 2^W-1).
    int m_phase = 0, m_wcnt = 0, m_pos = 0;
    int m_acc[NCH] = '{0, 0};
    logic [3:0] m_samp[NCH] = '{4'd0, 4'd0};
    logic exp_valid = 1'b0;
    int exp_d10[NCH] = '{0, 0};
    int exp_d6[NCH] = '{0, 0};
    logic [NCH-1:0] exp_sat10 = '0, exp_oor10 = '0, exp_sat6 = '0, exp_oor6 = '0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_wcnt = 0; m_pos = 0; exp_valid = 1'b0;
            exp_sat10 = '0; exp_oor10 = '0; exp_sat6 = '0; exp_oor6 = '0;
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_samp[i] = 4'd0; exp_d10[i] = 0; exp_d6[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (exp_valid && (exp_d10[i] < int'(lo10) || exp_d10[i] > int'(hi10))) exp_oor10[i] = 1'b1;
                else if (clr) exp_oor10[i] = 1'b0;
                if (exp_valid && (exp_d6[i] < int'(lo6) || exp_d6[i] > int'(hi6))) exp_oor6[i] = 1'b1;
                else if (clr) exp_oor6[i] = 1'b0;
                m_samp[i] = {m_samp[i][2:0], tgl[i]};
            end
            exp_valid = 1'b0;
            if (m_phase == 0) begin
                if (en) begin m_phase = 1; m_wcnt = 0; end
            end else if (m_phase == 1) begin
                m_wcnt++;
                if (m_wcnt == S + 1) begin
                    m_phase = 2; m_pos = 0;
                    for (int i = 0; i < NCH; i++) m_acc[i] = 0;
                end
            end else if (!en) begin
                m_phase = 0;
            end else begin
                for (int i = 0; i < NCH; i++)
                    if (m_samp[i][S] != m_samp[i][S+1]) m_acc[i]++;
                m_pos++;
                if (m_pos == N) begin
                    exp_valid = 1'b1;
                    for (int i = 0; i < NCH; i++) begin
                        exp_d10[i]   = (m_acc[i] > 1023) ? 1023 : m_acc[i];
                        exp_sat10[i] = (m_acc[i] > 1023);
                        exp_d6[i]    = (m_acc[i] > 63) ? 63 : m_acc[i];
                        exp_sat6[i]  = (m_acc[i] > 63);
                        m_acc[i] = 0;
                    end
                    m_pos = 0;
                end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic check_cycle();
        logic [NCH*W-1:0]  e10;
        logic [NCH*W6-1:0] e6;
        for (int i = 0; i < NCH; i++) begin
            e10[i*W +: W]   = exp_d10[i][W-1:0];
            e6[i*W6 +: W6]  = exp_d6[i][W6-1:0];
        end
        cmp("valid10", 32'(valid10), 32'(exp_valid));
        cmp("dout10",  32'(dout10),  32'(e10));
        cmp("sat10",   32'(sat10),   32'(exp_sat10));
        cmp("oor10",   32'(oor10),   32'(exp_oor10));
        cmp("valid6",  32'(valid6),  32'(exp_valid));
        cmp("dout6",   32'(dout6),   32'(e6));
        cmp("sat6",    32'(sat6),    32'(exp_sat6));
        cmp("oor6",    32'(oor6),    32'(exp_oor6));
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!valid10 && cyc < 600);
        if (!valid10) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_valid: got no strobe in %0d cycles, want one", cyc);
        end
    endtask

    initial begin
        int c, nv;
        int d0;
        tick();
        tick();
        cmp("rst_dout", 32'(dout10), 32'd0);
        cmp("rst_valid_sat_oor", 32'({valid10, sat10, oor10}), 32'd0);
        rst_n = 1'b1;
        en = 1'b1;

        // 1: nominal rates, latency from en and window period
        wait_valid(c);
        cmp("first_latency", 32'(c), 32'd260);
        d0 = int'(dout10[W-1:0]);
        cmp("first_dout0_near64", 32'(d0 >= 63 && d0 <= 65), 32'd1);
        wait_valid(c);
        cmp("period", 32'(c), 32'd256);
        cmp("dout_64_32", 32'(dout10), 32'({10'd32, 10'd64}));
        cmp("sat_nominal", 32'(sat10), 32'd0);

        // 2: saturation in the 6-bit instance
        per[0] = 2;
        wait_valid(c);
        wait_valid(c);
        cmp("fast_dout10", 32'(dout10[W-1:0]), 32'd128);
        cmp("fast_sat10", 32'(sat10[0]), 32'd0);
        cmp("fast_dout6", 32'(dout6[W6-1:0]), 32'd63);
        cmp("fast_sat6", 32'(sat6[0]), 32'd1);
        per[0] = 16;
        wait_valid(c);
        wait_valid(c);
        cmp("slow_dout6", 32'(dout6[W6-1:0]), 32'd16);
        cmp("slow_sat6", 32'(sat6[0]), 32'd0);

        // 3: limits, sticky oor, clear, clear against a failing valid
        per[0] = 4;
        wait_valid(c);
        lo10 = 10'd60;
        hi10 = 10'd70;
        wait_valid(c);
        tick();
        cmp("oor_first", 32'(oor10), 32'd2);
        per[1] = 4;
        wait_valid(c);
        wait_valid(c);
        tick();
        cmp("ch1_inrange", 32'(dout10[2*W-1:W]), 32'd64);
        cmp("oor_sticky", 32'(oor10), 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        cmp("oor_cleared", 32'(oor10), 32'd0);
        per[1] = 8;
        wait_valid(c);
        wait_valid(c);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cmp("oor_set_wins", 32'(oor10), 32'd2);

        // 4: en dropped mid-window, then relaunched
        wait_valid(c);
        for (int k = 0; k < 100; k++) tick();
        en = 1'b0;
        nv = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (valid10) nv++;
        end
        cmp("no_valid_when_off", 32'(nv), 32'd0);
        cmp("dout_held", 32'(dout10), 32'({10'd32, 10'd64}));
        en = 1'b1;
        wait_valid(c);
        cmp("relaunch_latency", 32'(c), 32'd260);

        // 5: asynchronous reset mid-window
        for (int k = 0; k < 50; k++) tick();
        #3 rst_n = 1'b0;
        #1;
        cmp("async_rst_dout", 32'(dout10), 32'd0);
        cmp("async_rst_flags", 32'({valid10, sat10, oor10}), 32'd0);
        cmp("async_rst_dout6", 32'(dout6), 32'd0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        wait_valid(c);
        cmp("post_rst_latency", 32'(c), 32'd260);
        wait_valid(c);
        cmp("post_rst_dout", 32'(dout10), 32'({10'd32, 10'd64}));

        // 6: single toggles around the window boundary
        per[0] = 0;
        per[1] = 0;
        wait_valid(c);
        wait_valid(c);
        cmp("idle_window", 32'(dout10), 32'd0);
        for (int k = 0; k < 253; k++) tick();
        shot_req[0]++;
        tick();
        shot_req[1]++;
        wait_valid(c);
        cmp("edge_in_terminal", 32'(dout10), 32'({10'd0, 10'd1}));
        wait_valid(c);
        cmp("edge_after_terminal", 32'(dout10), 32'({10'd1, 10'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
